// File: rtl/nibble_serial_adder_ctrl_if.sv
// Requester-side bus of the nibble-serial adder: start/done handshake,
// operands, carry-in and the registered result.
interface nibble_serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;

    modport master (
        output start, a, b, cin,
        input  busy, done, s, co
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, s, co
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle W-bit adder built from one 4-bit slice, least-significant
// nibble first, with the inter-nibble carry held in a register.
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input logic                    clk,
    input logic                    rst,
    nibble_serial_adder_ctrl_if.slave bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     opa;
    logic [W-1:0]     opb;
    logic [W-1:0]     sum;
    logic             carry;
    logic             co_r;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             last;
    logic [4:0]       slice;

    // A new request is taken only when the controller is ready.
    assign accept = ((state == IDLE) || (state == DONE)) && bus.start;
    assign last   = (idx == IDX_W'(NIBBLES - 1));

    // The single shared 4-bit adder slice, fed from the current nibble.
    assign slice = {1'b0, opa[4*idx +: 4]} + {1'b0, opb[4*idx +: 4]} + {4'b0, carry};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; a start seen in DONE re-enters RUN with no idle gap.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from state only, so busy and done never overlap.
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            RUN:     bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture on accept, then one nibble of sum written per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            co_r  <= 1'b0;
        end else if (accept) begin
            opa   <= bus.a;
            opb   <= bus.b;
            carry <= bus.cin;
            idx   <= '0;
            sum   <= '0;
        end else if (state == RUN) begin
            sum[4*idx +: 4] <= slice[3:0];
            carry           <= slice[4];
            if (last) co_r <= slice[4];
            else      idx  <= idx + 1'b1;
        end
    end

    assign bus.s  = sum;
    assign bus.co = co_r;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: directed vector table, multi-cycle
// corner sequences, and random regression at NIBBLES=4 and NIBBLES=2.
module tb_nibble_serial_adder_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    nibble_serial_adder_ctrl_if #(.NIBBLES(4)) bus4 ();
    nibble_serial_adder_ctrl_if #(.NIBBLES(2)) bus2 ();

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    nibble_serial_adder_ctrl #(.NIBBLES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_s;
        logic        exp_co;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one addition on the 16-bit unit; optionally pulse start mid-RUN.
    // Returns once done is seen (or the cycle budget expires).
    task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input bit glitch, output logic [15:0] s, output logic co,
                       output int lat, output int busy_n, output int both_n);
        bus4.start = 1'b1;
        bus4.a     = a;
        bus4.b     = b;
        bus4.cin   = cin;
        step();
        lat    = 1;
        busy_n = 0;
        both_n = 0;
        bus4.start = 1'b0;
        bus4.a     = 16'h0;
        bus4.b     = 16'h0;
        while (!bus4.done && lat < 20) begin
            if (bus4.busy) busy_n++;
            if (bus4.busy && bus4.done) both_n++;
            if (glitch && lat == 2) begin
                bus4.start = 1'b1;
                bus4.a     = 16'hAAAA;
                bus4.b     = 16'h5555;
            end else begin
                bus4.start = 1'b0;
            end
            step();
            lat++;
        end
        if (bus4.busy && bus4.done) both_n++;
        s  = bus4.s;
        co = bus4.co;
    endtask

    task automatic op2(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       output logic [7:0] s, output logic co, output int lat);
        bus2.start = 1'b1;
        bus2.a     = a;
        bus2.b     = b;
        bus2.cin   = cin;
        step();
        bus2.start = 1'b0;
        lat = 1;
        while (!bus2.done && lat < 20) begin
            step();
            lat++;
        end
        s  = bus2.s;
        co = bus2.co;
    endtask

    initial begin
        logic [15:0] s;
        logic        co;
        logic [7:0]  s2;
        logic        co2;
        logic [16:0] ref17;
        logic [8:0]  ref9;
        int          lat, busy_n, both_n, dones, gap;
        logic [15:0] ra, rb;
        logic [7:0]  ra2, rb2;
        logic        rc;

        checks = 0;
        errors = 0;
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[4] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0};

        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        step();
        step();
        check("reset_busy", 64'(bus4.busy), 64'd0);
        check("reset_done", 64'(bus4.done), 64'd0);
        check("reset_s",    64'(bus4.s),    64'd0);
        check("reset_co",   64'(bus4.co),   64'd0);
        rst = 1'b0;
        step();
        check("idle_busy", 64'(bus4.busy), 64'd0);

        // Directed vector table.
        foreach (vecs[i]) begin
            op4(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, s, co, lat, busy_n, both_n);
            check($sformatf("vec%0d_s", i),    64'(s),      64'(vecs[i].exp_s));
            check($sformatf("vec%0d_co", i),   64'(co),     64'(vecs[i].exp_co));
            check($sformatf("vec%0d_lat", i),  64'(lat),    64'd5);
            check($sformatf("vec%0d_busy", i), 64'(busy_n), 64'd4);
            check($sformatf("vec%0d_both", i), 64'(both_n), 64'd0);
            step();
            check($sformatf("vec%0d_done_drop", i), 64'(bus4.done), 64'd0);
            check($sformatf("vec%0d_idle_busy", i), 64'(bus4.busy), 64'd0);
            check($sformatf("vec%0d_hold_s", i),    64'(bus4.s),    64'(vecs[i].exp_s));
            check($sformatf("vec%0d_hold_co", i),   64'(bus4.co),   64'(vecs[i].exp_co));
        end

        // Start pulsed while busy must be ignored.
        op4(16'h00F0, 16'h0010, 1'b0, 1'b1, s, co, lat, busy_n, both_n);
        check("ign_s",   64'(s),   64'h0100);
        check("ign_co",  64'(co),  64'd0);
        check("ign_lat", 64'(lat), 64'd5);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus4.done || bus4.busy) dones++;
        end
        check("ign_single_done", 64'(dones), 64'd0);

        // Back-to-back with start held high.
        bus4.start = 1'b1;
        bus4.a = 16'h8000; bus4.b = 16'h8000; bus4.cin = 1'b0;
        step();
        bus4.a = 16'h0101; bus4.b = 16'h0202;
        lat = 1;
        while (!bus4.done && lat < 20) begin
            step();
            lat++;
        end
        check("b2b_first_lat", 64'(lat),     64'd5);
        check("b2b_first_s",   64'(bus4.s),  64'h0000);
        check("b2b_first_co",  64'(bus4.co), 64'd1);
        step();
        gap = 1;
        check("b2b_no_idle", 64'(bus4.busy), 64'd1);
        while (!bus4.done && gap < 20) begin
            step();
            gap++;
        end
        bus4.start = 1'b0;
        check("b2b_gap",      64'(gap),      64'd5);
        check("b2b_second_s", 64'(bus4.s),   64'h0303);
        check("b2b_second_co", 64'(bus4.co), 64'd0);
        step();
        check("b2b_idle", 64'(bus4.done | bus4.busy), 64'd0);

        // Reset in the middle of a RUN.
        bus4.start = 1'b1;
        bus4.a = 16'h1111; bus4.b = 16'h2222; bus4.cin = 1'b0;
        step();
        bus4.start = 1'b0;
        step();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        step();
        check("mid_rst_busy", 64'(bus4.busy), 64'd0);
        check("mid_rst_done", 64'(bus4.done), 64'd0);
        check("mid_rst_s",    64'(bus4.s),    64'd0);
        check("mid_rst_co",   64'(bus4.co),   64'd0);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus4.done) dones++;
        end
        check("mid_rst_no_done", 64'(dones), 64'd0);
        op4(16'h0009, 16'h0007, 1'b0, 1'b0, s, co, lat, busy_n, both_n);
        check("post_rst_s",  64'(s),  64'h0010);
        check("post_rst_co", 64'(co), 64'd0);
        step();

        // Random regression, 16-bit, against a plain 17-bit sum.
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            ref17 = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            op4(ra, rb, rc, 1'b0, s, co, lat, busy_n, both_n);
            check("rnd16_sum", 64'({co, s}), 64'(ref17));
            check("rnd16_lat", 64'(lat),     64'd5);
        end
        step();

        // Random regression, 8-bit, against a plain 9-bit sum.
        for (int i = 0; i < 1000; i++) begin
            ra2 = 8'($urandom);
            rb2 = 8'($urandom);
            rc  = 1'($urandom);
            ref9 = {1'b0, ra2} + {1'b0, rb2} + {8'd0, rc};
            op2(ra2, rb2, rc, s2, co2, lat);
            check("rnd8_sum", 64'({co2, s2}), 64'(ref9));
            check("rnd8_lat", 64'(lat),       64'd3);
        end
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
